// File: rtl/sel_pkg.sv
// Shared types, sizes and the round-robin search used by the select-bus arbiter.
// The search starts just after the previous owner and wraps around.
package sel_pkg;

    localparam int SEL_N      = 8;
    localparam int SEL_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sel_state_t;

    // First set bit of req found by scanning upward from last+1 with wraparound.
    // Callers only use the result when req is non-zero.
    function automatic logic [SEL_ADDR_W-1:0] rr_pick(
        input logic [SEL_N-1:0]      req,
        input logic [SEL_ADDR_W-1:0] last
    );
        logic [SEL_ADDR_W-1:0] idx;
        logic                  found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= SEL_N; i++) begin
            idx = last + SEL_ADDR_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sel_arbiter_if.sv
// Select-bus bundle between the requesters and the arbiter.
// The arbiter drives address/valid/grant/switch and samples req.
interface sel_arbiter_if;
    import sel_pkg::*;

    logic [SEL_N-1:0]      req;
    logic [SEL_ADDR_W-1:0] address;
    logic                  valid;
    logic [SEL_N-1:0]      grant;
    logic                  switch;

    modport master (
        input  req,
        output address,
        output valid,
        output grant,
        output switch
    );

    modport slave (
        output req,
        input  address,
        input  valid,
        input  grant,
        input  switch
    );

endinterface

// File: rtl/Decoder.sv
// Address/valid to one-hot select decoder shared with the datapath.
// The output is all zero whenever valid is low.
module Decoder
    import sel_pkg::*;
(
    input  logic [SEL_ADDR_W-1:0] address,
    input  logic                  valid,
    output logic [SEL_N-1:0]      grant
);

    always_comb begin
        grant = '0;
        if (valid) begin
            grant[address] = 1'b1;
        end
    end

endmodule

// File: rtl/sel_arbiter.sv
// Round-robin owner selection for the 8-way select bus, with hold-limit
// preemption and a one-cycle dead gap between consecutive owners.
module sel_arbiter
    import sel_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    sel_arbiter_if.master bus
);

    localparam int HOLD_W_RAW = $clog2(MAX_HOLD + 1);
    localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;
    localparam int LIM_INT    = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LIM_INT);

    sel_state_t            state;
    logic [SEL_ADDR_W-1:0] address;
    logic [SEL_ADDR_W-1:0] last;
    logic                  valid;
    logic                  switch;
    logic [HOLD_W-1:0]     hold_cnt;

    logic [SEL_ADDR_W-1:0] pick;
    logic [SEL_N-1:0]      owner_mask;
    logic                  any_req;
    logic                  owner_drop;
    logic                  others_pending;
    logic                  preempt;

    assign pick           = rr_pick(bus.req, last);
    assign any_req        = |bus.req;
    assign owner_mask     = SEL_N'(1) << address;
    assign owner_drop     = ~bus.req[address];
    assign others_pending = |(bus.req & ~owner_mask);
    assign preempt        = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM) && others_pending;

    // Owner sequencing; last is captured on leaving GRANT so the search at
    // the end of GAP starts just after the owner that was released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            address  <= '0;
            last     <= SEL_ADDR_W'(SEL_N - 1);
            valid    <= 1'b0;
            switch   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (any_req) begin
                        state    <= GRANT;
                        address  <= pick;
                        hold_cnt <= '0;
                        valid    <= 1'b1;
                        switch   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        valid  <= 1'b0;
                        switch <= 1'b0;
                    end
                end
                GRANT: begin
                    switch <= 1'b0;
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (owner_drop || preempt) begin
                        state <= GAP;
                        valid <= 1'b0;
                        last  <= address;
                    end
                end
                default: begin
                    state  <= IDLE;
                    valid  <= 1'b0;
                    switch <= 1'b0;
                end
            endcase
        end
    end

    // Grant comes from the same decoder the datapath uses for its select.
    Decoder u_decoder (
        .address (address),
        .valid   (valid),
        .grant   (bus.grant)
    );

    assign bus.address = address;
    assign bus.valid   = valid;
    assign bus.switch  = switch;

endmodule

// File: tb/tb_sel_arbiter.sv
// Directed bench for sel_arbiter with a hold limit of 4: reset, release,
// wraparound, preemption, sole requester and reset during a grant.
module tb_sel_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sel_arbiter_if bus_if ();

    sel_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] req_value);
        bus_if.req = req_value;
    endtask

    task automatic check_output(
        input string      tag,
        input logic [2:0] exp_address,
        input logic       exp_valid,
        input logic [7:0] exp_grant,
        input logic       exp_switch
    );
        checks++;
        assert (bus_if.address === exp_address) else begin
            errors++;
            $error("[TB] FAIL %s address got %0d want %0d", tag, bus_if.address, exp_address);
        end
        checks++;
        assert (bus_if.valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s valid got %b want %b", tag, bus_if.valid, exp_valid);
        end
        checks++;
        assert (bus_if.grant === exp_grant) else begin
            errors++;
            $error("[TB] FAIL %s grant got %h want %h", tag, bus_if.grant, exp_grant);
        end
        checks++;
        assert (bus_if.switch === exp_switch) else begin
            errors++;
            $error("[TB] FAIL %s switch got %b want %b", tag, bus_if.switch, exp_switch);
        end
    endtask

    initial begin
        logic [2:0] exp_a;
        logic       exp_v;
        logic       exp_s;
        logic [7:0] exp_g;
        logic [7:0] one;
        int         phase;

        checks = 0;
        errors = 0;
        one    = 8'h01;

        rst = 1'b1;
        apply_stimulus(8'hFF);
        #12;
        check_output("reset_hold", 3'd0, 1'b0, 8'h00, 1'b0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_output("first_grant", 3'd0, 1'b1, 8'h01, 1'b1);
        tick();
        check_output("switch_once", 3'd0, 1'b1, 8'h01, 1'b0);

        apply_stimulus(8'h05);
        apply_stimulus(8'h04);
        tick();
        check_output("release_gap", 3'd0, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("rotate_to_2", 3'd2, 1'b1, 8'h04, 1'b1);

        apply_stimulus(8'h40);
        tick();
        check_output("gap_before_6", 3'd2, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("owner_6", 3'd6, 1'b1, 8'h40, 1'b1);
        apply_stimulus(8'h41);
        apply_stimulus(8'h01);
        tick();
        check_output("gap_after_6", 3'd6, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("wrap_to_0", 3'd0, 1'b1, 8'h01, 1'b1);

        apply_stimulus(8'h03);
        for (int i = 1; i <= 13; i++) begin
            tick();
            phase = i % 5;
            exp_v = (phase != 4);
            exp_a = 3'((i / 5) % 2);
            exp_g = exp_v ? (one << exp_a) : 8'h00;
            exp_s = (phase == 0);
            check_output($sformatf("preempt_%0d", i), exp_a, exp_v, exp_g, exp_s);
        end

        apply_stimulus(8'h02);
        tick();
        check_output("simul_gap", 3'd0, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("simul_next", 3'd1, 1'b1, 8'h02, 1'b1);
        tick();
        check_output("simul_single", 3'd1, 1'b1, 8'h02, 1'b0);

        apply_stimulus(8'h80);
        tick();
        check_output("sole_gap", 3'd1, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("sole_start", 3'd7, 1'b1, 8'h80, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_output($sformatf("sole_%0d", i), 3'd7, 1'b1, 8'h80, 1'b0);
        end

        apply_stimulus(8'h20);
        tick();
        check_output("gap_before_5", 3'd7, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("owner_5", 3'd5, 1'b1, 8'h20, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_reset", 3'd0, 1'b0, 8'h00, 1'b0);
        apply_stimulus(8'h21);
        #1;
        rst = 1'b0;
        tick();
        check_output("restart_0", 3'd0, 1'b1, 8'h01, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
